// File: rtl/mandel_solver_scheduler.sv
// Frame controller: walks the H_RES x V_RES pixel grid, dispatches pixels to a bank of
// Mandelbrot solvers and funnels finished iteration counts to the frame buffer.
// Optional: define MANDEL_PERF_CNT_EN to add the cycle_count frame-time counter.
module mandel_solver_scheduler #(
    parameter int NUM_SOLVERS = 4,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int ADDR_W      = 19
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [26:0]               cr_init,
    input  logic [26:0]               ci_init,
    input  logic [26:0]               dx,
    input  logic [26:0]               dy,
    input  logic [12:0]               max_iter,
    output logic                      busy,
    output logic                      frame_done,
    output logic [NUM_SOLVERS-1:0]    slv_reset,
    output logic [27*NUM_SOLVERS-1:0] slv_cr,
    output logic [27*NUM_SOLVERS-1:0] slv_ci,
    output logic [12:0]               slv_max_iter,
    input  logic [NUM_SOLVERS-1:0]    slv_done,
    input  logic [13*NUM_SOLVERS-1:0] slv_iter,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [12:0]               wr_iter,
    input  logic                      wr_ready
`ifdef MANDEL_PERF_CNT_EN
    ,
    output logic [31:0]               cycle_count
`endif
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int IW = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                  state_q;
    logic [XW-1:0]           x_q;
    logic [YW-1:0]           y_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [26:0]             crCur_q;
    logic [26:0]             ciCur_q;
    logic [26:0]             crInit_q;
    logic [26:0]             dx_q;
    logic [26:0]             dy_q;
    logic [12:0]             maxIter_q;

    logic [NUM_SOLVERS-1:0]  slotBusy_q;
    logic [ADDR_W-1:0]       slotAddr_q [NUM_SOLVERS];
    logic [26:0]             slvCr_q    [NUM_SOLVERS];
    logic [26:0]             slvCi_q    [NUM_SOLVERS];
    logic [IW-1:0]           rrPtr_q;
    logic [IW-1:0]           rrPtr_d;

    logic                    wrValid_q;
    logic [ADDR_W-1:0]       wrAddr_q;
    logic [12:0]             wrIter_q;

    logic                    dispatchEn;
    logic [IW-1:0]           dispIdx;
    logic [NUM_SOLVERS-1:0]  dispVec;
    logic                    canLoad;
    logic                    wbEn;
    logic [IW-1:0]           wbIdx;
    logic                    lastPixel;
    logic                    rowEnd;
    logic                    drainDone;

    function automatic logic [IW-1:0] wrapIdx(input int v);
        return IW'((v >= NUM_SOLVERS) ? (v - NUM_SOLVERS) : v);
    endfunction

    assign rowEnd    = (x_q == XW'(H_RES - 1));
    assign lastPixel = rowEnd && (y_q == YW'(V_RES - 1));
    assign drainDone = (state_q == DRAIN) && (slotBusy_q == '0) && !wrValid_q;

    // Lowest-index free slot wins; descending scan lets the lowest index overwrite.
    always_comb begin
        dispatchEn = 1'b0;
        dispIdx    = '0;
        dispVec    = '0;
        if (state_q == RUN) begin
            for (int i = NUM_SOLVERS - 1; i >= 0; i--) begin
                if (!slotBusy_q[i]) begin
                    dispatchEn = 1'b1;
                    dispIdx    = IW'(i);
                end
            end
        end
        if (dispatchEn) begin
            dispVec[dispIdx] = 1'b1;
        end
    end

    // Round-robin pick among finished solvers, starting at the pointer.
    always_comb begin
        canLoad = !wrValid_q || wr_ready;
        wbEn    = 1'b0;
        wbIdx   = '0;
        for (int k = 0; k < NUM_SOLVERS; k++) begin
            if (!wbEn && canLoad &&
                slotBusy_q[wrapIdx(int'(rrPtr_q) + k)] &&
                slv_done[wrapIdx(int'(rrPtr_q) + k)]) begin
                wbEn  = 1'b1;
                wbIdx = wrapIdx(int'(rrPtr_q) + k);
            end
        end
        rrPtr_d = wrapIdx(int'(wbIdx) + 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            crCur_q    <= '0;
            ciCur_q    <= '0;
            crInit_q   <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            maxIter_q  <= '0;
            slotBusy_q <= '0;
            rrPtr_q    <= '0;
            wrValid_q  <= 1'b0;
            wrAddr_q   <= '0;
            wrIter_q   <= '0;
            for (int i = 0; i < NUM_SOLVERS; i++) begin
                slotAddr_q[i] <= '0;
                slvCr_q[i]    <= '0;
                slvCi_q[i]    <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RUN;
                        crInit_q  <= cr_init;
                        dx_q      <= dx;
                        dy_q      <= dy;
                        maxIter_q <= max_iter;
                        crCur_q   <= cr_init;
                        ciCur_q   <= ci_init;
                        x_q       <= '0;
                        y_q       <= '0;
                        addr_q    <= '0;
                    end
                end
                RUN: begin
                    if (dispatchEn) begin
                        addr_q <= addr_q + 1'b1;
                        if (lastPixel) begin
                            state_q <= DRAIN;
                        end else if (rowEnd) begin
                            x_q     <= '0;
                            y_q     <= y_q + 1'b1;
                            crCur_q <= crInit_q;
                            ciCur_q <= ciCur_q - dy_q;
                        end else begin
                            x_q     <= x_q + 1'b1;
                            crCur_q <= crCur_q + dx_q;
                        end
                    end
                end
                DRAIN: begin
                    if (drainDone) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (dispatchEn) begin
                slotBusy_q[dispIdx] <= 1'b1;
                slotAddr_q[dispIdx] <= addr_q;
                slvCr_q[dispIdx]    <= crCur_q;
                slvCi_q[dispIdx]    <= ciCur_q;
            end

            // Dispatch and writeback never touch the same slot in one cycle.
            if (wbEn) begin
                slotBusy_q[wbIdx] <= 1'b0;
                wrValid_q         <= 1'b1;
                wrAddr_q          <= slotAddr_q[wbIdx];
                wrIter_q          <= slv_iter[int'(wbIdx)*13 +: 13];
                rrPtr_q           <= rrPtr_d;
            end else if (wr_ready) begin
                wrValid_q <= 1'b0;
            end
        end
    end

    assign busy         = (state_q != IDLE);
    assign frame_done   = drainDone;
    assign slv_reset    = {NUM_SOLVERS{reset}} | dispVec;
    assign slv_max_iter = maxIter_q;
    assign wr_en        = wrValid_q;
    assign wr_addr      = wrAddr_q;
    assign wr_iter      = wrIter_q;

    for (genvar g = 0; g < NUM_SOLVERS; g++) begin : g_pack
        assign slv_cr[g*27 +: 27] = slvCr_q[g];
        assign slv_ci[g*27 +: 27] = slvCi_q[g];
    end

`ifdef MANDEL_PERF_CNT_EN
    logic [31:0] cycleCount_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCount_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            cycleCount_q <= '0;
        end else if (busy) begin
            cycleCount_q <= cycleCount_q + 32'd1;
        end
    end

    assign cycle_count = cycleCount_q;
`endif

endmodule

// File: tb/tb_mandel_solver_scheduler.sv
// Scoreboard bench for mandel_solver_scheduler on a 4x2 screen with two behavioural solvers.
// Expected dispatch operands and writes are queued at stimulus time and consumed by a monitor.
module tb_mandel_solver_scheduler;

    localparam int NS   = 2;
    localparam int HR   = 4;
    localparam int VR   = 2;
    localparam int AW   = 3;
    localparam int NPIX = HR * VR;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [26:0]      cr_init;
    logic [26:0]      ci_init;
    logic [26:0]      dx;
    logic [26:0]      dy;
    logic [12:0]      max_iter;
    logic             busy;
    logic             frame_done;
    logic [NS-1:0]    slv_reset;
    logic [27*NS-1:0] slv_cr;
    logic [27*NS-1:0] slv_ci;
    logic [12:0]      slv_max_iter;
    logic [NS-1:0]    slv_done;
    logic [13*NS-1:0] slv_iter;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [12:0]      wr_iter;
    logic             wr_ready;
`ifdef MANDEL_PERF_CNT_EN
    logic [31:0]      cycle_count;
`endif

    mandel_solver_scheduler #(
        .NUM_SOLVERS(NS),
        .H_RES      (HR),
        .V_RES      (VR),
        .ADDR_W     (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cr_init     (cr_init),
        .ci_init     (ci_init),
        .dx          (dx),
        .dy          (dy),
        .max_iter    (max_iter),
        .busy        (busy),
        .frame_done  (frame_done),
        .slv_reset   (slv_reset),
        .slv_cr      (slv_cr),
        .slv_ci      (slv_ci),
        .slv_max_iter(slv_max_iter),
        .slv_done    (slv_done),
        .slv_iter    (slv_iter),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_iter     (wr_iter),
        .wr_ready    (wr_ready)
`ifdef MANDEL_PERF_CNT_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [12:0]   iter;
    } wr_t;

    typedef struct {
        logic [26:0] cr;
        logic [26:0] ci;
    } disp_t;

    // Hand-computed pixel operands: cr = -2.0,-1.5,-1.0,-0.5 per column, ci = 1.0,0.5 per row.
    logic [26:0] crTab [HR] = '{27'h7000000, 27'h7400000, 27'h7800000, 27'h7C00000};
    logic [26:0] ciTab [VR] = '{27'h0800000, 27'h0400000};

    wr_t   expQ[$];
    disp_t dispQ[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int writeCount;
    int frameDoneCount;
    int dispCount;
    int busyCnt;
    int lateDisp;
    int fIdx;
    int writeCycle [NPIX];
    bit strictOrder;
    bit countDisp;
    bit pendChk [NS];
    disp_t pend [NS];
    logic prevStall;
    logic [AW-1:0] stallAddr;
    logic [12:0] stallIter;

    // Behavioural solvers: done appears latency cycles after the reset edge.
    logic [NS-1:0] sDone = '0;
    logic [12:0]   sIter [NS] = '{default: '0};
    int            sCnt  [NS] = '{default: 0};
    int            latBase [NS];
    bit            latVary;

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (slv_reset[i]) begin
                sCnt[i]  <= 1;
                sDone[i] <= 1'b0;
            end else if (!sDone[i]) begin
                if (sCnt[i] >= latBase[i] + (latVary ? int'(slv_cr[i*27+22 +: 2]) : 0)) begin
                    sDone[i] <= 1'b1;
                    sIter[i] <= {3'b000, slv_cr[i*27+22 +: 5], slv_ci[i*27+22 +: 5]} ^ slv_max_iter;
                end else begin
                    sCnt[i] <= sCnt[i] + 1;
                end
            end
        end
    end

    assign slv_done = sDone;

    always_comb begin
        slv_iter = '0;
        for (int i = 0; i < NS; i++) begin
            slv_iter[i*13 +: 13] = sIter[i];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] expIter(input int p, input logic [12:0] mi);
        logic [26:0] cr;
        logic [26:0] ci;
        cr = crTab[p % HR];
        ci = ciTab[p / HR];
        return {3'b000, cr[26:22], ci[26:22]} ^ mi;
    endfunction

    // Monitor: checks dispatched operands one cycle after each solver reset, and every accepted write.
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < NS; i++) pendChk[i] = 1'b0;
            prevStall = 1'b0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (pendChk[i]) begin
                    checkOutput("slv_cr", 32'(slv_cr[i*27 +: 27]), 32'(pend[i].cr));
                    checkOutput("slv_ci", 32'(slv_ci[i*27 +: 27]), 32'(pend[i].ci));
                    pendChk[i] = 1'b0;
                end
            end
            for (int i = 0; i < NS; i++) begin
                if (slv_reset[i]) begin
                    dispCount++;
                    if (countDisp) lateDisp++;
                    if (dispQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL dispatch_extra: got dispatch on slot %0d expected none", i);
                    end else begin
                        pend[i]    = dispQ.pop_front();
                        pendChk[i] = 1'b1;
                    end
                end
            end
            if (prevStall) begin
                checkOutput("held_wr_en", 32'(wr_en), 32'd1);
                checkOutput("held_wr_addr", 32'(wr_addr), 32'(stallAddr));
                checkOutput("held_wr_iter", 32'(wr_iter), 32'(stallIter));
            end
            prevStall = wr_en && !wr_ready;
            stallAddr = wr_addr;
            stallIter = wr_iter;
            if (wr_en && wr_ready) begin
                fIdx = -1;
                for (int j = 0; j < expQ.size(); j++) begin
                    if (fIdx < 0 && expQ[j].addr == wr_addr) fIdx = j;
                end
                if (fIdx < 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL write_unexpected: got addr %0d expected none", wr_addr);
                end else begin
                    checkOutput("wr_iter", 32'(wr_iter), 32'(expQ[fIdx].iter));
                    if (strictOrder) checkOutput("wr_order", 32'(fIdx), 32'd0);
                    expQ.delete(fIdx);
                end
                writeCount++;
                writeCycle[wr_addr] = cyc;
            end
            if (frame_done) frameDoneCount++;
            if (busy) busyCnt++;
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [12:0] mi);
        wr_t   w;
        disp_t d;
        for (int p = 0; p < NPIX; p++) begin
            w.addr = AW'(p);
            w.iter = expIter(p, mi);
            expQ.push_back(w);
            d.cr = crTab[p % HR];
            d.ci = ciTab[p / HR];
            dispQ.push_back(d);
        end
        writeCount     = 0;
        frameDoneCount = 0;
        dispCount      = 0;
        busyCnt        = 0;
        cr_init  = 27'h7000000;
        ci_init  = 27'h0800000;
        dx       = 27'h0400000;
        dy       = 27'h0400000;
        max_iter = mi;
        start    = 1'b1;
        stepCycle();
        start    = 1'b0;
    endtask

    task automatic waitFrame(input string name);
        int n;
        n = 0;
        while (frameDoneCount == 0 && n < 400) begin
            stepCycle();
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout: got no frame_done expected one within 400 cycles", name);
        end
        stepCycle();
    endtask

    task automatic frameChecks(input string name);
        checkOutput({name, "_writes"}, 32'(writeCount), NPIX);
        checkOutput({name, "_frame_done"}, 32'(frameDoneCount), 32'd1);
        checkOutput({name, "_pending_writes"}, 32'(expQ.size()), 32'd0);
        checkOutput({name, "_pending_dispatch"}, 32'(dispQ.size()), 32'd0);
        checkOutput({name, "_busy"}, 32'(busy), 32'd0);
`ifdef MANDEL_PERF_CNT_EN
        checkOutput({name, "_cycle_count_nonzero"}, 32'(cycle_count != 0), 32'd1);
        checkOutput({name, "_cycle_count"}, cycle_count, 32'(busyCnt));
        repeat (5) stepCycle();
        checkOutput({name, "_cycle_count_frozen"}, cycle_count, 32'(busyCnt));
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish within 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        cr_init     = '0;
        ci_init     = '0;
        dx          = '0;
        dy          = '0;
        max_iter    = '0;
        wr_ready    = 1'b1;
        latBase     = '{2, 2};
        latVary     = 1'b1;
        strictOrder = 1'b0;
        countDisp   = 1'b0;
        lateDisp    = 0;

        stepCycle();
        checkOutput("rst_slv_reset", 32'(slv_reset), 32'h3);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_iter", 32'(wr_iter), 32'd0);
        checkOutput("rst_slv_max_iter", 32'(slv_max_iter), 32'd0);
        stepCycle();
        reset = 1'b0;
        stepCycle();
        checkOutput("post_rst_slv_reset", 32'(slv_reset), 32'd0);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        checkOutput("post_rst_slv_cr", 32'(slv_cr[26:0]), 32'd0);
        checkOutput("post_rst_frame_done", 32'(frame_done), 32'd0);
`ifdef MANDEL_PERF_CNT_EN
        checkOutput("post_rst_cycle_count", cycle_count, 32'd0);
`endif

        $display("[TB] basic frame");
        applyStimulus(13'h100);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        waitFrame("basic");
        frameChecks("basic");

        $display("[TB] backpressure frame with ignored start");
        applyStimulus(13'h0AA);
        repeat (6) stepCycle();
        wr_ready = 1'b0;
        repeat (10) stepCycle();
        cr_init = 27'h0000000;
        dx      = 27'h0100000;
        start   = 1'b1;
        stepCycle();
        start     = 1'b0;
        lateDisp  = 0;
        countDisp = 1'b1;
        repeat (9) stepCycle();
        countDisp = 1'b0;
        checkOutput("no_dispatch_stalled", 32'(lateDisp), 32'd0);
        wr_ready = 1'b1;
        waitFrame("backpressure");
        frameChecks("backpressure");

        $display("[TB] simultaneous done frame");
        latVary     = 1'b0;
        latBase     = '{3, 2};
        strictOrder = 1'b1;
        applyStimulus(13'h001);
        waitFrame("simul");
        frameChecks("simul");
        for (int k = 0; k < NPIX / 2; k++) begin
            checkOutput("pair_gap", 32'(writeCycle[2*k+1] - writeCycle[2*k]), 32'd1);
        end
        strictOrder = 1'b0;

        $display("[TB] abort frame");
        latVary = 1'b1;
        latBase = '{2, 2};
        applyStimulus(13'h055);
        begin
            int n;
            n = 0;
            while (writeCount < 3 && n < 200) begin
                stepCycle();
                n++;
            end
            if (n >= 200) begin
                total++;
                bad++;
                $display("[TB] FAIL abort_wait_timeout: got %0d writes expected 3", writeCount);
            end
        end
        reset = 1'b1;
        stepCycle();
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_wr_en", 32'(wr_en), 32'd0);
        checkOutput("abort_slv_reset", 32'(slv_reset), 32'h3);
        reset = 1'b0;
        expQ.delete();
        dispQ.delete();
        stepCycle();
        checkOutput("abort_after_slv_reset", 32'(slv_reset), 32'd0);
        checkOutput("abort_after_wr_en", 32'(wr_en), 32'd0);

        $display("[TB] frame after abort");
        applyStimulus(13'h1FF);
        waitFrame("restart");
        frameChecks("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
